npu_result_writer: RTL and testbench
====================================

Name: npu_result_writer

Overview:
- Drains the 3x3 systolic-array result words (c1..c9) after the NPU asserts ack.
- Writes them back as a serial stream of (addr, data) write transactions into the NPU result region, using a valid/ready handshake.
- Sits between the npu core's result outputs and the shared memory write port used by the host/CPU side. It is the read-out end of the load -> compute -> ack flow.

Parameters:
- DATA_W, 32, width of one result word
- N_RES, 9, number of result words (MUL_SIZE*MUL_SIZE)
- ADDR_W, 5, write-address width (32-entry NPU memory)
- C_BASE, 18, first result address; A occupies 0..8, B occupies 9..17, C occupies 18..26

Ports:
- clk, input, 1, system clock, rising edge
- rst, input, 1, reset; synchronous, active-low (0 = reset)
- ack_in, input, 1, done level from the npu core
- c_flat, input, N_RES*DATA_W, results packed as {c9,...,c1}; c1 in bits [DATA_W-1:0]
- wr_valid, output, 1, write request valid
- wr_ready, input, 1, write port accepts the request this cycle
- wr_addr, output, ADDR_W, write address
- wr_data, output, DATA_W, write data
- busy, output, 1, a burst is in progress
- done, output, 1, single-cycle pulse after the last write is accepted
- err, output, 1, sticky: ack rise seen while busy
- err_clr, input, 1, clears err

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, idx=0.
  - ack_d resets to 1, so an ack already high at reset release does NOT start a burst.
  - Reset mid-burst aborts immediately. The remaining words are discarded, with no partial-completion done.
- ack_d is ack_in registered every cycle. A rise is ack_in==1 && ack_d==0.
- IDLE:
  - On a rise: snapshot all of c_flat into snap[0..N_RES-1], set idx=0, go to SEND.
  - wr_valid=1 and busy=1 from the next cycle. Latency is rise cycle t -> first wr_valid at t+1.
- SEND:
  - Drive wr_valid=1, wr_addr=C_BASE+idx (ADDR_W-bit add, no wrap for defaults), wr_data=snap[idx].
  - On wr_valid&&wr_ready: if idx==N_RES-1, go to DONE; else idx++.
  - While wr_valid&&!wr_ready: addr and data are held stable. wr_valid never drops before acceptance.
  - With wr_ready held at 1, the burst is exactly N_RES consecutive cycles.
  - Outputs must come from state/idx/snap, never combinationally from wr_ready. wr_ready may depend combinationally on wr_valid.
- DONE:
  - One cycle: wr_valid=0, busy=0, done=1. Next cycle go to IDLE, done=0.
  - A rise seen in DONE is treated as IDLE (it starts a new burst next cycle) and does not set err.
- Results are taken from the snapshot only. c_flat changes after capture have no effect.
- ack rise while in SEND: it is ignored, with no restart and no re-snapshot, and err is set to 1.
- err_clr and a new err event in the same cycle: set wins. err_clr has no other effect.
- ack held high continuously produces exactly one burst. A new burst needs ack to fall and rise again.

Decomposition:
- Shared package npu_pkg holds:
  - DATA_W=32, MUL_SIZE=3, N_RES=MUL_SIZE*MUL_SIZE, ADDR_W=5
  - A_BASE=0, B_BASE=9, C_BASE=18
  - state enum {IDLE, SEND, DONE}
- The npu core and the host loader use the same package.
- One natural sub-module, npu_res_snap: an N_RES x DATA_W capture register bank with a load strobe and an idx read mux. It is reusable by a future read-back path.
- Edge detect and FSM stay in npu_result_writer.

Test Plan:
- Basic burst: c_k = 32'h11*k (k=1..9), wr_ready=1, single ack rise at t -> writes (18,0x11),(19,0x22)...(26,0x99) on cycles t+1..t+9, done=1 at t+10, busy=0 at t+10.
- Backpressure: same data, wr_ready low on every other cycle -> each word is held stable until accepted, 9 accepted writes in order, done one cycle after the 9th acceptance, no duplicates.
- Snapshot isolation: change c_flat to all 0xDEADBEEF one cycle after the ack rise -> written data is still 0x11..0x99.
- Ack level/overlap: ack held high 40 cycles -> exactly one burst, err=0. A second rise during SEND -> burst unaffected and err=1. err_clr=1 -> err=0.
- Reset mid-burst: rst=0 after the 4th accepted write (addr 21) -> next cycle wr_valid=0, busy=0, no done pulse. With ack still high after rst=1, no new burst starts until ack falls and rises.
- Back-to-back: an ack fall and rise landing on the DONE cycle -> new burst starts with wr_valid=1 on the following cycle, err stays 0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU constants: matrix geometry, memory map of the 32-entry NPU memory,
// and the result-writer state encoding.
package npu_pkg;

    localparam int DATA_W   = 32;
    localparam int MUL_SIZE = 3;
    localparam int N_RES    = MUL_SIZE * MUL_SIZE;
    localparam int ADDR_W   = 5;
    localparam int IDX_W    = $clog2(N_RES);

    localparam int A_BASE = 0;
    localparam int B_BASE = 9;
    localparam int C_BASE = 18;

    localparam logic [ADDR_W-1:0] C_BASE_A = ADDR_W'(C_BASE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_RES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/npu_res_snap.sv
// Capture bank for the systolic-array result words: a load strobe copies the
// whole packed vector, and an index mux reads one word back.
module npu_res_snap
    import npu_pkg::*;
#(
    parameter int WORD_W = DATA_W,
    parameter int DEPTH  = N_RES,
    parameter int SEL_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [DEPTH*WORD_W-1:0] d_flat,
    input  logic [SEL_W-1:0]        idx,
    output logic [WORD_W-1:0]       q
);

    logic [WORD_W-1:0] snap_q [DEPTH];

    // Word bank: cleared on reset, fully overwritten on load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                snap_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                snap_q[i] <= d_flat[i*WORD_W +: WORD_W];
            end
        end
    end

    // Read mux; out-of-range indices read as zero.
    always_comb begin
        q = '0;
        if (idx < SEL_W'(DEPTH)) begin
            q = snap_q[idx];
        end else begin
            q = '0;
        end
    end

endmodule

// File: rtl/npu_result_writer.sv
// Drains the nine result words into the C region of NPU memory as a serial
// valid/ready write burst, triggered by a rising edge of the core's ack level.
module npu_result_writer
    import npu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ack_in,
    input  logic [N_RES*DATA_W-1:0] c_flat,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic                    err_clr
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ack_q;
    logic              err_q, err_d;
    logic              rise_s;
    logic              load_s;
    logic [DATA_W-1:0] snap_word_s;

    assign rise_s = ack_in & ~ack_q;

    npu_res_snap #(
        .WORD_W (DATA_W),
        .DEPTH  (N_RES),
        .SEL_W  (IDX_W)
    ) u_snap (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .d_flat (c_flat),
        .idx    (idx_q),
        .q      (snap_word_s)
    );

    // State, index, ack history and sticky error; ack history resets high so a
    // level already present at reset release is not mistaken for a new rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ack_q   <= ack_in;
            err_q   <= err_d;
        end
    end

    // Next-state logic; DONE behaves like IDLE for a fresh rise.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (rise_s) begin
                    state_d = SEND;
                    idx_d   = '0;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (wr_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        if (rise_s && (state_q == SEND)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Outputs decode only registered state, so nothing depends on wr_ready.
    assign wr_valid = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign done     = (state_q == DONE);
    assign wr_addr  = (state_q == SEND) ? (C_BASE_A + ADDR_W'(idx_q)) : '0;
    assign wr_data  = (state_q == SEND) ? snap_word_s : '0;
    assign err      = err_q;

endmodule

// File: tb/tb_npu_result_writer.sv
// Scoreboard bench for npu_result_writer: expected (addr,data) pairs are queued
// when a burst is triggered and popped as writes are accepted.
module tb_npu_result_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         ack_in;
    logic [287:0] c_flat;
    logic         wr_valid;
    logic         wr_ready;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         busy;
    logic         done;
    logic         err;
    logic         err_clr;

    int total = 0;
    int bad   = 0;
    logic [36:0] sb_q[$];

    npu_result_writer dut (
        .clk      (clk),
        .rst      (rst),
        .ack_in   (ack_in),
        .c_flat   (c_flat),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        logic [4:0]  a;
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            a = 5'd18 + 5'(k);
            d = 32'h11 * 32'(k + 1);
            sb_q.push_back({a, d});
        end
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < max_cyc) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                cyc();
                n++;
            end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    // Scoreboard monitor: pops on every accepted write, checks held address on stalls.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst === 1'b1 && wr_valid === 1'b1) begin
            if (wr_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_write", 64'(wr_addr), 64'h3f);
                end else begin
                    e = sb_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e[36:32]));
                    chk("wr_data", 64'(wr_data), 64'(e[31:0]));
                end
            end else if (sb_q.size() != 0) begin
                e = sb_q[0];
                chk("stall_addr", 64'(wr_addr), 64'(e[36:32]));
                chk("stall_data", 64'(wr_data), 64'(e[31:0]));
            end
        end
    end

    initial begin
        int acc;
        int dones;
        int extra;
        rst      = 1'b0;
        ack_in   = 1'b0;
        wr_ready = 1'b1;
        err_clr  = 1'b0;
        for (int k = 0; k < 9; k++) begin
            c_flat[k*32 +: 32] = 32'h11 * 32'(k + 1);
        end
        cyc();
        cyc();
        chk("rst_valid", 64'(wr_valid), 64'd0);
        chk("rst_busy",  64'(busy),     64'd0);
        chk("rst_done",  64'(done),     64'd0);
        chk("rst_err",   64'(err),      64'd0);
        chk("rst_addr",  64'(wr_addr),  64'd0);
        chk("rst_data",  64'(wr_data),  64'd0);
        rst = 1'b1;
        cyc();

        // Basic burst with exact latency
        ack_in = 1'b1;
        push_words(9);
        cyc();
        for (int k = 0; k < 9; k++) begin
            chk("basic_valid", 64'(wr_valid), 64'd1);
            chk("basic_busy",  64'(busy),     64'd1);
            cyc();
        end
        chk("basic_done",   64'(done),     64'd1);
        chk("basic_busy0",  64'(busy),     64'd0);
        chk("basic_valid0", 64'(wr_valid), 64'd0);
        cyc();
        chk("basic_done0",  64'(done),     64'd0);
        chk("basic_sb",     64'(sb_q.size()), 64'd0);

        // Backpressure: ready low on every other cycle
        ack_in = 1'b0;
        cyc();
        ack_in = 1'b1;
        push_words(9);
        cyc();
        acc = 0;
        for (int n = 0; n < 40 && acc < 9; n++) begin
            wr_ready = n[0];
            #1;
            if (wr_valid && wr_ready) acc++;
            cyc();
        end
        wr_ready = 1'b1;
        chk("bp_accepts", 64'(acc),  64'd9);
        chk("bp_done",    64'(done), 64'd1);
        chk("bp_sb",      64'(sb_q.size()), 64'd0);

        // Snapshot isolation
        ack_in = 1'b0;
        cyc();
        ack_in = 1'b1;
        push_words(9);
        cyc();
        c_flat = {9{32'hDEADBEEF}};
        wait_done("snap_done", 20);
        chk("snap_sb", 64'(sb_q.size()), 64'd0);
        for (int k = 0; k < 9; k++) begin
            c_flat[k*32 +: 32] = 32'h11 * 32'(k + 1);
        end

        // Ack held high for 40 cycles gives one burst
        ack_in = 1'b0;
        cyc();
        ack_in = 1'b1;
        push_words(9);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            cyc();
            if (done) dones++;
        end
        chk("level_dones", 64'(dones), 64'd1);
        chk("level_err",   64'(err),   64'd0);
        chk("level_sb",    64'(sb_q.size()), 64'd0);

        // Second rise during SEND sets err, burst unaffected
        ack_in = 1'b0;
        cyc();
        ack_in = 1'b1;
        push_words(9);
        cyc();
        cyc();
        ack_in = 1'b0;
        cyc();
        ack_in = 1'b1;
        cyc();
        chk("ovl_err", 64'(err), 64'd1);
        wait_done("ovl_done", 20);
        chk("ovl_sb",    64'(sb_q.size()), 64'd0);
        chk("ovl_err_k", 64'(err), 64'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("clr_err", 64'(err), 64'd0);

        // Reset after the 4th accepted write
        ack_in = 1'b0;
        cyc();
        ack_in = 1'b1;
        push_words(4);
        cyc();
        for (int k = 0; k < 4; k++) cyc();
        rst = 1'b0;
        cyc();
        chk("mrst_valid", 64'(wr_valid), 64'd0);
        chk("mrst_busy",  64'(busy),     64'd0);
        chk("mrst_done",  64'(done),     64'd0);
        chk("mrst_sb",    64'(sb_q.size()), 64'd0);
        rst = 1'b1;
        extra = 0;
        for (int n = 0; n < 15; n++) begin
            cyc();
            if (wr_valid || done) extra++;
        end
        chk("mrst_norestart", 64'(extra), 64'd0);
        ack_in = 1'b0;
        cyc();
        ack_in = 1'b1;
        push_words(9);
        cyc();
        chk("mrst_new_valid", 64'(wr_valid), 64'd1);
        wait_done("mrst_new_done", 20);
        chk("mrst_new_sb", 64'(sb_q.size()), 64'd0);

        // Back-to-back: new rise landing on the DONE cycle
        ack_in = 1'b0;
        cyc();
        ack_in = 1'b1;
        push_words(9);
        cyc();
        cyc();
        ack_in = 1'b0;
        wait_done("b2b_done1", 20);
        ack_in = 1'b1;
        push_words(9);
        cyc();
        chk("b2b_valid", 64'(wr_valid), 64'd1);
        chk("b2b_addr",  64'(wr_addr),  64'd18);
        chk("b2b_err",   64'(err),      64'd0);
        wait_done("b2b_done2", 20);
        chk("b2b_err2",  64'(err),      64'd0);
        cyc();
        chk("final_sb",  64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
